// File: rtl/spi_flash_loader_pkg.sv
// Shared definitions for the SPI flash loader: SPI master register map,
// control-register layout, flash opcode, loader FSM states and helpers.
package spi_flash_loader_pkg;

    // SPI master register addresses
    localparam logic [1:0] SPI_ADDR_DATAREG = 2'd0;  // write starts a transfer
    localparam logic [1:0] SPI_ADDR_IMMDATA = 2'd1;  // last received word, no transfer
    localparam logic [1:0] SPI_ADDR_CTRLREG = 2'd2;

    // Transfer size codes held in the control register
    localparam logic [1:0] SIZE_BYTE   = 2'b00;
    localparam logic [1:0] SIZE_HALF   = 2'b01;
    localparam logic [1:0] SIZE_TRIPLE = 2'b10;
    localparam logic [1:0] SIZE_WORD   = 2'b11;

    // Control register bit positions
    localparam int CTRL_SIZE_LSB = 0;
    localparam int CTRL_SS_LSB   = 7;
    localparam int CTRL_BE_BIT   = 16;

    // Flash READ opcode
    localparam logic [7:0] SPI_CMD_READ = 8'h03;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG,
        ST_CMD,
        ST_CWAIT,
        ST_DUMMY,
        ST_DWAIT,
        ST_FETCH,
        ST_STORE,
        ST_DONE
    } ld_state_e;

    // Control word: 32-bit transfers, big-endian shifting, given slave select
    function automatic logic [31:0] ctrl_word(input logic [1:0] ss);
        logic [31:0] w;
        w = '0;
        w[CTRL_SIZE_LSB +: 2] = SIZE_WORD;
        w[CTRL_SS_LSB +: 2]   = ss;
        w[CTRL_BE_BIT]        = 1'b1;
        return w;
    endfunction

    // Reverse byte order so the first byte off the wire lands in [7:0]
    function automatic logic [31:0] byte_swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/spi_flash_loader.sv
// Streams word_count 32-bit words from SPI flash (READ command) into RAM by
// sequencing register accesses on the SPI master's bus port. While idle the
// CPU bus passes straight through to the master; while loading the loader
// owns the port and any CPU access is held stalled.
//
// Bus handshake (CPU side and master side alike): an access is presented when
// select is high with a non-zero we (write) or rd (read); it is accepted in
// the cycle where the matching busy (wbusy for writes, rbusy for reads) is low,
// and the initiator must hold it unchanged until then.
module spi_flash_loader
    import spi_flash_loader_pkg::*;
#(
    parameter int         MEM_AW    = 14,
    parameter int         SS_SEL    = 0,
    parameter int         BYTE_SWAP = 1,
    parameter logic [7:0] CMD_READ  = SPI_CMD_READ
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [23:0]       flash_addr,
    input  logic [MEM_AW-1:0] mem_base,
    input  logic [15:0]       word_count,
    output logic              busy,
    output logic              done,
    input  logic              cpu_select,
    input  logic [3:0]        cpu_we,
    input  logic              cpu_rd,
    input  logic [1:0]        cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_wbusy,
    output logic              cpu_rbusy,
    output logic [31:0]       cpu_rdata,
    output logic              spi_select,
    output logic [3:0]        spi_we,
    output logic              spi_rd,
    output logic [1:0]        spi_addr,
    output logic [31:0]       spi_wdata,
    input  logic              spi_wbusy,
    input  logic              spi_rbusy,
    input  logic [31:0]       spi_rdata,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output ld_state_e         dbg_state
);

    ld_state_e         state_q, state_d;
    logic [23:0]       fa_q;
    logic [MEM_AW-1:0] base_q;
    logic [15:0]       cnt_q;
    logic [15:0]       idx_q;
    logic [31:0]       data_q;
    logic              zero_done_q;

    logic              ld_select;
    logic [3:0]        ld_we;
    logic              ld_rd;
    logic [1:0]        ld_addr;
    logic [31:0]       ld_wdata;

    logic              start_load;
    logic              last_word;

    assign start_load = (state_q == ST_IDLE) && start && (word_count != 16'd0);
    assign last_word  = (idx_q == cnt_q - 16'd1);

    assign dbg_state  = state_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE) || zero_done_q;
    assign mem_we     = (state_q == ST_STORE);
    assign mem_waddr  = base_q + MEM_AW'(idx_q);
    assign mem_wdata  = data_q;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load parameters, word index and captured flash data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fa_q        <= '0;
            base_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= (state_q == ST_IDLE) && start && (word_count == 16'd0);
            if (start_load) begin
                fa_q   <= flash_addr;
                base_q <= mem_base;
                cnt_q  <= word_count;
                idx_q  <= '0;
            end
            if (state_q == ST_FETCH) begin
                data_q <= (BYTE_SWAP != 0) ? byte_swap32(spi_rdata) : spi_rdata;
            end
            if (state_q == ST_STORE) begin
                idx_q <= idx_q + 16'd1;
            end
        end
    end

    // Next state and the loader's own SPI bus access for this cycle
    always_comb begin
        state_d   = state_q;
        ld_select = 1'b0;
        ld_we     = 4'h0;
        ld_rd     = 1'b0;
        ld_addr   = SPI_ADDR_DATAREG;
        ld_wdata  = 32'h0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_load) state_d = ST_CFG;
            end
            ST_CFG: begin
                ld_select = 1'b1;
                ld_addr   = SPI_ADDR_CTRLREG;
                ld_we     = 4'b0111;
                ld_wdata  = ctrl_word(2'(SS_SEL));
                state_d   = ST_CMD;
            end
            ST_CMD: begin
                ld_select = 1'b1;
                ld_we     = 4'hF;
                ld_wdata  = {CMD_READ, fa_q};
                state_d   = ST_CWAIT;
            end
            ST_CWAIT: begin
                ld_select = 1'b1;
                if (!spi_wbusy) state_d = ST_DUMMY;
            end
            ST_DUMMY: begin
                ld_select = 1'b1;
                ld_we     = 4'hF;
                ld_wdata  = 32'hFFFF_FFFF;
                state_d   = ST_DWAIT;
            end
            ST_DWAIT: begin
                ld_select = 1'b1;
                if (!spi_wbusy) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ld_select = 1'b1;
                ld_rd     = 1'b1;
                ld_addr   = SPI_ADDR_IMMDATA;
                state_d   = ST_STORE;
            end
            ST_STORE: begin
                state_d = last_word ? ST_DONE : ST_DUMMY;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus ownership: CPU passes through when idle, otherwise it is stalled
    always_comb begin
        if (state_q == ST_IDLE) begin
            spi_select = cpu_select;
            spi_we     = cpu_we;
            spi_rd     = cpu_rd;
            spi_addr   = cpu_addr;
            spi_wdata  = cpu_wdata;
            cpu_wbusy  = spi_wbusy;
            cpu_rbusy  = spi_rbusy;
            cpu_rdata  = spi_rdata;
        end else begin
            spi_select = ld_select;
            spi_we     = ld_we;
            spi_rd     = ld_rd;
            spi_addr   = ld_addr;
            spi_wdata  = ld_wdata;
            cpu_wbusy  = cpu_select;
            cpu_rbusy  = cpu_select;
            cpu_rdata  = 32'h0;
        end
    end

endmodule

// File: tb/tb_spi_flash_loader.sv
// Bench for spi_flash_loader with a behavioural SPI master + flash model.
// Flash content: the byte at address a is a[7:0].
module tb_spi_flash_loader;
    import spi_flash_loader_pkg::*;

    localparam int MEM_AW = 14;
    localparam int EW     = MEM_AW + 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              start = 1'b0;
    logic [23:0]       flash_addr = '0;
    logic [MEM_AW-1:0] mem_base = '0;
    logic [15:0]       word_count = '0;
    logic              busy, done;
    logic              cpu_select = 1'b0;
    logic [3:0]        cpu_we = 4'h0;
    logic              cpu_rd = 1'b0;
    logic [1:0]        cpu_addr = 2'd0;
    logic [31:0]       cpu_wdata = '0;
    logic              cpu_wbusy, cpu_rbusy;
    logic [31:0]       cpu_rdata;
    logic              spi_select;
    logic [3:0]        spi_we;
    logic              spi_rd;
    logic [1:0]        spi_addr;
    logic [31:0]       spi_wdata;
    logic              spi_wbusy, spi_rbusy;
    logic [31:0]       spi_rdata;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    ld_state_e         dbg_state;

    spi_flash_loader #(
        .MEM_AW(MEM_AW), .SS_SEL(0), .BYTE_SWAP(1), .CMD_READ(8'h03)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .flash_addr(flash_addr),
        .mem_base(mem_base), .word_count(word_count), .busy(busy), .done(done),
        .cpu_select(cpu_select), .cpu_we(cpu_we), .cpu_rd(cpu_rd),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wbusy(cpu_wbusy),
        .cpu_rbusy(cpu_rbusy), .cpu_rdata(cpu_rdata),
        .spi_select(spi_select), .spi_we(spi_we), .spi_rd(spi_rd),
        .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_wbusy(spi_wbusy),
        .spi_rbusy(spi_rbusy), .spi_rdata(spi_rdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .dbg_state(dbg_state)
    );

    // ---------------- SPI master + flash model ----------------
    logic        shifting;
    int          sh_cnt;
    logic [31:0] rx_word, pend_rx;
    logic        expect_cmd;
    logic [23:0] ptr;
    logic [31:0] cmd_word, ctrl_last, last_tx;
    logic [3:0]  ctrl_we_last;
    int          ctrl_cnt, tx_cnt;

    assign spi_wbusy = spi_select && (spi_addr == 2'd0) && shifting;
    assign spi_rbusy = 1'b0;
    assign spi_rdata = rx_word;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            shifting <= 1'b0; sh_cnt <= 0; rx_word <= '0; pend_rx <= '0;
            expect_cmd <= 1'b0; ptr <= '0; cmd_word <= '0; ctrl_last <= '0;
            ctrl_we_last <= '0; ctrl_cnt <= 0; tx_cnt <= 0; last_tx <= '0;
        end else begin
            if (shifting) begin
                if (sh_cnt == 1) begin
                    shifting <= 1'b0;
                    rx_word  <= pend_rx;
                end else begin
                    sh_cnt <= sh_cnt - 1;
                end
            end else if (spi_select && spi_we != 4'h0 && spi_addr == 2'd0) begin
                shifting <= 1'b1;
                sh_cnt   <= 32;
                tx_cnt   <= tx_cnt + 1;
                last_tx  <= spi_wdata;
                if (expect_cmd) begin
                    cmd_word   <= spi_wdata;
                    ptr        <= spi_wdata[23:0];
                    pend_rx    <= 32'hFFFF_FFFF;
                    expect_cmd <= 1'b0;
                end else begin
                    pend_rx <= {ptr[7:0], 8'(ptr + 24'd1), 8'(ptr + 24'd2), 8'(ptr + 24'd3)};
                    ptr     <= ptr + 24'd4;
                end
            end
            if (spi_select && spi_we != 4'h0 && spi_addr == 2'd2) begin
                ctrl_cnt     <= ctrl_cnt + 1;
                ctrl_last    <= spi_wdata;
                ctrl_we_last <= spi_we;
                expect_cmd   <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int sel_cycles = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [MEM_AW-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic monitor();
        logic [EW-1:0] e, a;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (spi_select) sel_cycles++;
            if (mem_we) begin
                a = {mem_waddr, mem_wdata};
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL mem_write: unexpected addr %h data %h", mem_waddr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("mem_write", 64'(a), 64'(e));
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_load(input logic [23:0] fa, input logic [MEM_AW-1:0] base, input logic [15:0] cnt);
        @(negedge clk);
        start = 1'b1; flash_addr = fa; mem_base = base; word_count = cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check(name, 64'(got), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dc0, sc0, tx0;
        logic stall_ok, got, seen_store;

        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_select", 64'(spi_select), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Main load: 4 words from 0x001000 to RAM 0x20
        push_exp(14'h0020, 32'h0302_0100);
        push_exp(14'h0021, 32'h0706_0504);
        push_exp(14'h0022, 32'h0B0A_0908);
        push_exp(14'h0023, 32'h0F0E_0D0C);
        dc0 = done_cnt;
        do_load(24'h001000, 14'h0020, 16'd4);
        check("main_busy", 64'(busy), 64'd1);
        repeat (10) @(negedge clk);
        start = 1'b1; flash_addr = 24'h000200; mem_base = 14'h007F; word_count = 16'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400, "main_done");
        repeat (5) @(negedge clk);
        check("main_done_once", 64'(done_cnt - dc0), 64'd1);
        check("main_busy_end", 64'(busy), 64'd0);
        check("ctrl_writes", 64'(ctrl_cnt), 64'd1);
        check("ctrl_word", 64'(ctrl_last), 64'h0001_0003);
        check("ctrl_we", 64'(ctrl_we_last), 64'h7);
        check("cmd_word", 64'(cmd_word), 64'h0300_1000);
        check("main_queue", 64'(exp_q.size()), 64'd0);

        // Zero count: done next cycle, no bus activity
        sc0 = sel_cycles;
        dc0 = done_cnt;
        do_load(24'h001000, 14'h0030, 16'd0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("zero_done_pulse", 64'(done), 64'd0);
        repeat (5) @(negedge clk);
        check("zero_select", 64'(sel_cycles - sc0), 64'd0);
        check("zero_done_once", 64'(done_cnt - dc0), 64'd1);

        // RAM address wrap
        push_exp(14'h3FFF, 32'h0302_0100);
        push_exp(14'h0000, 32'h0706_0504);
        do_load(24'h000100, 14'h3FFF, 16'd2);
        wait_done(300, "wrap_done");
        repeat (3) @(negedge clk);
        check("wrap_queue", 64'(exp_q.size()), 64'd0);

        // CPU write during load is stalled, then reaches the master
        push_exp(14'h0040, 32'h0302_0100);
        push_exp(14'h0041, 32'h0706_0504);
        push_exp(14'h0042, 32'h0B0A_0908);
        push_exp(14'h0043, 32'h0F0E_0D0C);
        do_load(24'h001000, 14'h0040, 16'd4);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dbg_state == ST_DWAIT) begin
                got = 1'b1;
                break;
            end
        end
        check("cpu_reach_dwait", 64'(got), 64'd1);
        cpu_select = 1'b1; cpu_we = 4'hF; cpu_addr = 2'd0; cpu_wdata = 32'hA5A5_5A5A;
        stall_ok = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!cpu_wbusy) stall_ok = 1'b0;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("cpu_load_done", 64'(got), 64'd1);
        check("cpu_stalled", 64'(stall_ok), 64'd1);
        tx0 = tx_cnt;
        @(negedge clk);
        check("cpu_released", 64'(cpu_wbusy), 64'd0);
        @(negedge clk);
        cpu_select = 1'b0; cpu_we = 4'h0;
        check("cpu_tx_count", 64'(tx_cnt - tx0), 64'd1);
        check("cpu_tx_data", 64'(last_tx), 64'hA5A5_5A5A);
        check("cpu_queue", 64'(exp_q.size()), 64'd0);
        repeat (40) @(negedge clk);

        // Reset in DWAIT of word 2: only word 1 is written, no done
        push_exp(14'h0060, 32'h0302_0100);
        do_load(24'h001000, 14'h0060, 16'd4);
        seen_store = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dbg_state == ST_STORE) seen_store = 1'b1;
            if (seen_store && dbg_state == ST_DWAIT) begin
                got = 1'b1;
                break;
            end
        end
        check("rst_reach_dwait2", 64'(got), 64'd1);
        dc0 = done_cnt;
        reset = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_select", 64'(spi_select), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt - dc0), 64'd0);
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
